// File: rtl/snake_body_engine_if.sv
// Scan-query and game-control bundle between the snake engine and its host.
// The host drives scan position, steering and apple; the engine answers.
interface snake_body_engine_if;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [1:0] dir_in;
  logic       dir_valid;
  logic       game_en;
  logic [5:0] apple_x;
  logic [4:0] apple_y;
  logic [1:0] snake;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [4:0] length;
  logic       eat;
  logic       game_over;

  modport master (
    output x_pos, y_pos, dir_in, dir_valid,
    output game_en, apple_x, apple_y,
    input  snake, head_x, head_y, length,
    input  eat, game_over
  );

  modport slave (
    input  x_pos, y_pos, dir_in, dir_valid,
    input  game_en, apple_x, apple_y,
    output snake, head_x, head_y, length,
    output eat, game_over
  );
endinterface

// File: rtl/snake_body_engine.sv
// Snake game-state engine: segment list, move stepping, collisions, growth,
// and the registered per-pixel cell-class query for the VGA colour logic.
module snake_body_engine #(
  parameter int MAX_LEN  = 16,
  parameter int MOVE_DIV = 12_500_000
) (
  input  logic               clk,
  input  logic               rst,
  snake_body_engine_if.slave bus
);
  localparam int CW = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);
  localparam logic [1:0] UP = 2'b00;
  localparam logic [1:0] DN = 2'b01;
  localparam logic [1:0] LT = 2'b10;
  localparam logic [1:0] RT = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    cur_q, pend_q;
  logic [5:0]    sx [MAX_LEN];
  logic [4:0]    sy [MAX_LEN];
  logic [4:0]    len_q;
  logic          eat_q;
  logic [1:0]    cls_q, cls_d;

  logic       step, wall_hit, self_hit, collide;
  logic       apple_hit, grow;
  logic [5:0] nx;
  logic [4:0] ny;
  logic [5:0] cx;
  logic [4:0] cy;
  logic       on_scr, q_wall, body_hit;

  always_comb begin
    nx = sx[0];
    ny = sy[0];
    unique case (pend_q)
      UP: ny = sy[0] - 5'd1;
      DN: ny = sy[0] + 5'd1;
      LT: nx = sx[0] - 6'd1;
      RT: nx = sx[0] + 6'd1;
      default: ;
    endcase
  end

  // Tail is excluded: it vacates its cell on the same step.
  always_comb begin
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if ((5'(i) + 5'd2 <= len_q) &&
          sx[i] == nx && sy[i] == ny)
        self_hit = 1'b1;
  end

  assign wall_hit  = nx == 6'd0 || nx == 6'd39 ||
                     ny == 5'd0 || ny == 5'd29;
  assign step      = state_q == RUN && bus.game_en &&
                     cnt_q == LAST;
  assign collide   = step && (wall_hit || self_hit);
  assign apple_hit = nx == bus.apple_x && ny == bus.apple_y;
  assign grow      = len_q < 5'(MAX_LEN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.game_en) state_d = RUN;
      RUN:     if (collide) state_d = OVER;
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  assign cx     = bus.x_pos[9:4];
  assign cy     = bus.y_pos[8:4];
  assign on_scr = bus.x_pos < 10'd640 && bus.y_pos < 10'd480;
  assign q_wall = cx == 6'd0 || cx == 6'd39 ||
                  cy == 5'd0 || cy == 5'd29;

  always_comb begin
    body_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (5'(i) < len_q && sx[i] == cx && sy[i] == cy)
        body_hit = 1'b1;
  end

  always_comb begin
    cls_d = 2'b00;
    if (!on_scr)                        cls_d = 2'b00;
    else if (q_wall)                    cls_d = 2'b11;
    else if (sx[0] == cx && sy[0] == cy) cls_d = 2'b01;
    else if (body_hit)                  cls_d = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= RT;
      pend_q  <= RT;
      len_q   <= 5'd3;
      eat_q   <= 1'b0;
      cls_q   <= 2'b00;
      for (int i = 0; i < MAX_LEN; i++) begin
        sx[i] <= '0;
        sy[i] <= '0;
      end
      sx[0] <= 6'd20;
      sx[1] <= 6'd19;
      sx[2] <= 6'd18;
      sy[0] <= 5'd15;
      sy[1] <= 5'd15;
      sy[2] <= 5'd15;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      eat_q   <= step && !collide && apple_hit;
      if (state_q != RUN)
        cnt_q <= '0;
      else if (bus.game_en)
        cnt_q <= step ? '0 : cnt_q + CW'(1);
      if (bus.dir_valid && state_q != OVER &&
          bus.dir_in != {cur_q[1], ~cur_q[0]})
        pend_q <= bus.dir_in;
      if (step)
        cur_q <= pend_q;
      if (step && !collide) begin
        for (int i = 1; i < MAX_LEN; i++) begin
          sx[i] <= sx[i-1];
          sy[i] <= sy[i-1];
        end
        sx[0] <= nx;
        sy[0] <= ny;
        if (apple_hit && grow)
          len_q <= len_q + 5'd1;
      end
    end
  end

  assign bus.snake     = cls_q;
  assign bus.head_x    = sx[0];
  assign bus.head_y    = sy[0];
  assign bus.length    = len_q;
  assign bus.eat       = eat_q;
  assign bus.game_over = state_q == OVER;
endmodule

// File: tb/tb_snake_body_engine.sv
// Bench for snake_body_engine: queue-based game model checked every cycle,
// directed scenarios with literal expectations, then randomized play.
module tb_snake_body_engine;
  localparam int MAX_LEN  = 16;
  localparam int MOVE_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  snake_body_engine_if bus();

  snake_body_engine #(.MAX_LEN(MAX_LEN), .MOVE_DIV(MOVE_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model: queue of live cells, head first
  int qx[$] = '{20, 19, 18};
  int qy[$] = '{15, 15, 15};
  int m_state = 0;
  int m_phase = 0;
  int m_cur = 3;
  int m_pend = 3;
  int m_eat = 0;
  int m_snake = 0;
  int m_steps = 0;
  int mnx, mny, moc, mos;
  bit mhit, meat;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit on_wall(int x, int y);
    return x == 0 || x == 39 || y == 0 || y == 29;
  endfunction

  function automatic int cls(int px, int py);
    int cx = px / 16;
    int cy = py / 16;
    if (px >= 640 || py >= 480) return 0;
    if (on_wall(cx, cy)) return 3;
    if (cx == qx[0] && cy == qy[0]) return 1;
    for (int i = 1; i < qx.size(); i++)
      if (cx == qx[i] && cy == qy[i]) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      qx = '{20, 19, 18};
      qy = '{15, 15, 15};
      m_state = 0; m_phase = 0;
      m_cur = 3; m_pend = 3;
      m_eat = 0; m_snake = 0;
    end else begin
      m_snake = cls(int'(bus.x_pos), int'(bus.y_pos));
      moc = m_cur;
      mos = m_state;
      meat = 1'b0;
      if (m_state == 1 && bus.game_en) begin
        if (m_phase == MOVE_DIV - 1) begin
          m_phase = 0;
          m_steps++;
          mnx = qx[0] + int'(m_pend == 3) - int'(m_pend == 2);
          mny = qy[0] + int'(m_pend == 1) - int'(m_pend == 0);
          mhit = on_wall(mnx, mny);
          for (int i = 1; i <= qx.size() - 2; i++)
            if (qx[i] == mnx && qy[i] == mny) mhit = 1'b1;
          m_cur = m_pend;
          if (mhit) m_state = 2;
          else begin
            meat = mnx == int'(bus.apple_x) && mny == int'(bus.apple_y);
            qx.push_front(mnx);
            qy.push_front(mny);
            if (!meat || qx.size() > MAX_LEN) begin
              void'(qx.pop_back());
              void'(qy.pop_back());
            end
          end
        end else m_phase++;
      end else if (m_state == 0 && bus.game_en) m_state = 1;
      if (bus.dir_valid && mos != 2 && int'(bus.dir_in) != (moc ^ 1))
        m_pend = int'(bus.dir_in);
      m_eat = int'(meat);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("snake", int'(bus.snake), m_snake);
      chk("head_x", int'(bus.head_x), qx[0]);
      chk("head_y", int'(bus.head_y), qy[0]);
      chk("length", int'(bus.length), qx.size());
      chk("eat", int'(bus.eat), m_eat);
      chk("game_over", int'(bus.game_over), int'(m_state == 2));
    end
  end

  task automatic query(int x, int y);
    bus.x_pos = 10'(x);
    bus.y_pos = 10'(y);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    bus.game_en = 1'b0;
    bus.dir_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_step();
    int s0 = m_steps;
    for (int i = 0; i < 4 * MOVE_DIV; i++) begin
      @(negedge clk);
      if (m_steps != s0) return;
    end
    total++;
    bad++;
    $display("FAIL step_timeout: got no step want step at %0t", $time);
  endtask

  task automatic strobe(int d);
    bus.dir_in = 2'(d);
    bus.dir_valid = 1'b1;
    @(negedge clk);
    bus.dir_valid = 1'b0;
  endtask

  task automatic apple(int x, int y);
    bus.apple_x = 6'(x);
    bus.apple_y = 5'(y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int over_cnt, ax, ay, k;
    bus.x_pos = '0; bus.y_pos = '0;
    bus.dir_in = '0; bus.dir_valid = 1'b0;
    bus.game_en = 1'b0;
    apple(5, 5);
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_len", int'(bus.length), 3);
    chk("rst_hx", int'(bus.head_x), 20);
    chk("rst_hy", int'(bus.head_y), 15);
    chk("rst_snake", int'(bus.snake), 0);
    chk("rst_over", int'(bus.game_over), 0);
    query(0, 0);
    @(negedge clk) chk("q_wall", int'(bus.snake), 3);
    query(700, 10);
    @(negedge clk) chk("q_off", int'(bus.snake), 0);
    query(304, 240);
    @(negedge clk) chk("q_body", int'(bus.snake), 2);

    // first step: 4 cycles after entering RUN
    bus.game_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_step_hx", int'(bus.head_x), 20);
    @(negedge clk);
    chk("step1_hx", int'(bus.head_x), 21);
    chk("step1_len", int'(bus.length), 3);
    query(336, 240);
    @(negedge clk) chk("q_head", int'(bus.snake), 1);
    query(288, 240);
    @(negedge clk) chk("q_old_tail", int'(bus.snake), 0);
    query(304, 240);
    @(negedge clk) chk("q_seg2", int'(bus.snake), 2);

    // apple capture and growth to saturation
    do_rst();
    apple(21, 15);
    bus.game_en = 1'b1;
    wait_step();
    chk("eat_hi", int'(bus.eat), 1);
    chk("eat_len", int'(bus.length), 4);
    query(288, 240);
    @(negedge clk);
    chk("eat_lo", int'(bus.eat), 0);
    chk("tail_kept", int'(bus.snake), 2);
    for (int n = 0; n < 20 && qx.size() < MAX_LEN; n++) begin
      apple(qx[0] + 1, 15);
      wait_step();
    end
    apple(qx[0] + 1, 15);
    wait_step();
    chk("len_sat", int'(bus.length), MAX_LEN);
    apple(39, 15);
    for (int n = 0; n < 10 && m_state != 2; n++) wait_step();
    chk("wall_over", int'(bus.game_over), 1);
    chk("wall_hx", int'(bus.head_x), 38);
    chk("wall_no_eat", int'(bus.eat), 0);
    strobe(0);
    repeat (12) @(negedge clk);
    chk("over_hx", int'(bus.head_x), 38);
    chk("over_hy", int'(bus.head_y), 15);
    do_rst();
    @(negedge clk);
    chk("rst2_len", int'(bus.length), 3);
    chk("rst2_hx", int'(bus.head_x), 20);
    chk("rst2_over", int'(bus.game_over), 0);

    // reversal dropped; reversal then valid turn in one period
    apple(5, 5);
    bus.game_en = 1'b1;
    strobe(2);
    wait_step();
    chk("rev_hx", int'(bus.head_x), 21);
    strobe(1);
    wait_step();
    chk("down_hy", int'(bus.head_y), 16);
    strobe(0);
    strobe(2);
    wait_step();
    chk("left_hx", int'(bus.head_x), 20);
    chk("left_hy", int'(bus.head_y), 16);

    // self collision at length 5
    do_rst();
    apple(21, 15);
    bus.game_en = 1'b1;
    wait_step();
    apple(22, 15);
    wait_step();
    apple(5, 5);
    chk("grow5", int'(bus.length), 5);
    strobe(0); wait_step();
    strobe(2); wait_step();
    strobe(1); wait_step();
    chk("self_over", int'(bus.game_over), 1);
    chk("self_hx", int'(bus.head_x), 21);
    chk("self_hy", int'(bus.head_y), 14);

    // tail chase in a 2x2 loop
    do_rst();
    apple(21, 15);
    bus.game_en = 1'b1;
    wait_step();
    apple(5, 5);
    for (int n = 0; n < 2; n++) begin
      strobe(0); wait_step();
      strobe(2); wait_step();
      strobe(1); wait_step();
      strobe(3); wait_step();
    end
    chk("chase_over", int'(bus.game_over), 0);
    chk("chase_len", int'(bus.length), 4);
    chk("chase_hx", int'(bus.head_x), 21);
    chk("chase_hy", int'(bus.head_y), 15);

    // randomized play
    over_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      over_cnt = (m_state == 2) ? over_cnt + 1 : 0;
      rst = over_cnt > 6 || $urandom_range(299) == 0;
      bus.game_en = $urandom_range(15) != 0;
      bus.dir_valid = $urandom_range(5) == 0;
      bus.dir_in = 2'($urandom_range(3));
      if ($urandom_range(2) == 0) begin
        ax = qx[0] + int'(m_pend == 3) - int'(m_pend == 2);
        ay = qy[0] + int'(m_pend == 1) - int'(m_pend == 0);
        apple(ax, ay);
      end else if ($urandom_range(7) == 0)
        apple($urandom_range(39), $urandom_range(29));
      if ($urandom_range(1) == 0)
        query($urandom_range(1023), $urandom_range(1023));
      else begin
        k = $urandom_range(qx.size() - 1);
        query(qx[k] * 16 + $urandom_range(15),
              qy[k] * 16 + $urandom_range(15));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Game-state engine that owns the snake's segment list and answers the VGA scan's per-pixel cell query. Each cycle it takes the scan position (x_pos, y_pos) and returns the 2-bit cell class NONE/HEAD/BODY/WALL consumed by the VGA controller's colour logic. On a periodic move tick it also advances the snake, handles growth on apple capture, and detects wall and self collisions.

## Interface
- MAX_LEN, 16: segment storage depth; maximum snake length.
- MOVE_DIV, 12_500_000: clk cycles per move step (≥2).
- clk  in  1  system clock (same clock as VGA controller)
- rst  in  1  reset rst, synchronous, active-high; clock clk
- x_pos  in  10  scan pixel column; values ≥640 are off-screen
- y_pos  in  10  scan pixel row; values ≥480 are off-screen
- dir_in  in  2  requested direction: 00 up, 01 down, 10 left, 11 right
- dir_valid  in  1  one-cycle strobe qualifying dir_in
- game_en  in  1  level; high = run/start, low = pause
- apple_x  in  6  apple cell column (0..39)
- apple_y  in  5  apple cell row (0..29)
- snake  out  2  cell class for queried pixel: 00 NONE, 01 HEAD, 10 BODY, 11 WALL
- head_x  out  6  current head cell column
- head_y  out  5  current head cell row
- length  out  5  current segment count (3..MAX_LEN)
- eat  out  1  one-cycle pulse on apple capture
- game_over  out  1  level; high once a collision occurs

## Operation
- Grid: 40×30 cells of 16×16 px; cell = (x_pos[9:4], y_pos[9:4]). WALL = column 0 or 39, or row 0 or 29.
- Storage: seg[0] = head … seg[length-1] = tail, each 6+5 bits.
- Reset values: seg0=(20,15), seg1=(19,15), seg2=(18,15), others (0,0); length=3; cur_dir=pend_dir=right; state IDLE; tick counter 0; snake=NONE; eat=0; game_over=0; head_x=20, head_y=15.
- FSM: IDLE → RUN when game_en=1. RUN → OVER on collision. OVER holds until rst. In IDLE and OVER the snake is frozen and the tick counter is held at 0.
- Direction: a dir_valid strobe latches dir_in into pend_dir unless it is the reverse of cur_dir (up↔down, left↔right); reversal requests are dropped. cur_dir ← pend_dir on each step. Last valid strobe before the step wins.
- Tick counter: runs 0..MOVE_DIV-1 only in RUN with game_en=1. It holds its value while game_en=0 (pause). A step occurs on the cycle the counter equals MOVE_DIV-1; the counter then wraps to 0.
- Step: nh = seg0 moved one cell in pend_dir.
  - nh on wall: state→OVER, game_over=1, segments unchanged.
  - nh equals any seg[i] with 1≤i≤length-2: state→OVER, same. The tail, seg[length-1], is excluded because it vacates its cell.
  - Otherwise: seg[i]←seg[i-1] for i≥1, and seg0←nh.
  - If nh==(apple_x,apple_y): eat pulse, and length←length+1, saturating at MAX_LEN. The old tail is retained by the shift.
- Wall has priority over apple: an apple placed on a wall cell is never eaten.
- Query: pixel on-screen and in a wall cell → WALL; else cell==seg0 → HEAD; else cell==seg[i], 1≤i<length → BODY; else NONE. Off-screen → NONE. Segments at index ≥ length are ignored.

## Timing
- snake is registered: it reflects the x_pos/y_pos presented on the previous cycle (1-cycle latency). The query uses segment state as of that same previous cycle.
- Step updates (segments, length, head_x/head_y, cur_dir) are visible on the cycle after the step cycle.
- eat and game_over assert on the cycle after the step cycle. eat lasts exactly 1 cycle.
- A dir_valid arriving on the step cycle itself is not used for that step; it applies to the next step.
- Simultaneous apple and collision on the same step: collision wins and eat stays 0.
- rst in any state restores all reset values on the next cycle, including mid-step and in OVER.

## Test plan
- Reset, MOVE_DIV=4, game_en=1: the first step occurs 4 cycles after entering RUN → head_x=21, length=3, seg2=(19,15). A query at pixel (336,240) returns HEAD one cycle later, and a query at (288,240) returns NONE.
- Pixel queries with (x_pos,y_pos)=(0,0) → WALL, (700,10) → NONE, (304,240) after reset → BODY. Each result appears exactly 1 cycle after the input.
- Apple at (21,15), first step → eat high for exactly 1 cycle, length=4, and the tail stays at (18,15). Repeat captures until length reaches MAX_LEN; after that, length holds at MAX_LEN.
- dir_in=left (a reversal) while moving right → ignored, and the head keeps moving right. Strobe up then left within one step period → cur_dir becomes left after the step.
- Run right unobstructed to column 38, then step once more → game_over=1, state OVER, and head_x stays 38. Further ticks and dir strobes have no effect. rst restores the initial state.
- Grow to length 5, then issue turns up, left, down → self-hit on the down step, game_over=1. Also check the tail-chase case with length 4 in a 2×2 loop → no collision.
